regwrite_arb: RTL and testbench

REGWRITE_ARB -- requirements
Module: regwrite_arb

---
 rtl/regwrite_arb_pkg.sv | 29 ++
 rtl/regwrite_arb_if.sv | 34 +++
 rtl/regwrite_arb_queue.sv | 82 ++++++++
 rtl/regwrite_arb.sv | 157 +++++++++++++++
 tb/tb_regwrite_arb.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regwrite_arb_pkg.sv
// Shared constants, types and tag-ordering helper for the register-write arbiter.
package regwrite_arb_pkg;

  localparam logic [4:0] REG_ZR   = 5'd31;
  localparam int         NUM_REGS = 32;
  localparam int         TAG_W    = 3;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [4:0]       reg_idx_t;

  // Round-robin pointer encoding: whose turn it is on the next contended cycle.
  localparam logic [0:0] RR_A = 1'b0;
  localparam logic [0:0] RR_B = 1'b1;

  typedef struct packed {
    tag_t seq;
    logic rr;
    logic grant_a;
    logic grant_b;
  } regwrite_dbg_t;

  // x is older than y when y lies 1..3 steps ahead of x modulo 2**TAG_W.
  function automatic logic tag_older(tag_t x, tag_t y);
    tag_t diff;
    diff = y - x;
    return (diff != '0) && !diff[TAG_W-1];
  endfunction

endpackage

// File: rtl/regwrite_arb_if.sv
// Requester handshakes, register-file write port, busy scoreboard and debug state.
interface regwrite_arb_if #(
  parameter int DATA_W = 64
);
  import regwrite_arb_pkg::*;

  // Valid/ready: a transfer happens on a posedge where valid=1 and ready=1; the
  // payload (reg, data) is captured on that edge. ready never depends on valid.
  logic              a_valid;
  logic              a_ready;
  reg_idx_t          a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  reg_idx_t          b_reg;
  logic [DATA_W-1:0] b_data;

  logic              wr_en;
  reg_idx_t          wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       busy;
  regwrite_dbg_t     dbg;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, busy, dbg
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, busy, dbg
  );

endinterface

// File: rtl/regwrite_arb_queue.sv
// Per-requester FIFO of {tag, reg, data} with head view and per-register occupancy mask.
module regwrite_queue
  import regwrite_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int QDEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  tag_t                push_tag_i,
  input  reg_idx_t            push_reg_i,
  input  logic [DATA_W-1:0]   push_data_i,
  input  logic                pop_i,
  output tag_t                head_tag_o,
  output reg_idx_t            head_reg_o,
  output logic [DATA_W-1:0]   head_data_o,
  output logic                head_valid_o,
  output logic                full_o,
  output logic [NUM_REGS-1:0] occ_mask_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  tag_t              tag_mem_q  [QDEPTH];
  reg_idx_t          reg_mem_q  [QDEPTH];
  logic [DATA_W-1:0] data_mem_q [QDEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o       = (cnt_q == CNT_W'(QDEPTH));
  assign head_valid_o = (cnt_q != '0);
  assign do_push      = push_i && !full_o;
  assign do_pop       = pop_i && head_valid_o;

  assign head_tag_o  = tag_mem_q[rd_ptr_q];
  assign head_reg_o  = reg_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      tag_mem_q[wr_ptr_q]  <= push_tag_i;
      reg_mem_q[wr_ptr_q]  <= push_reg_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    occ_mask_o = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - rd_ptr_q} < cnt_q) begin
        occ_mask_o[reg_mem_q[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regwrite_arb.sv
// Two-requester register-file write arbiter: tagged queues, same-register ordering,
// round-robin otherwise, one registered write per cycle and a pending-write scoreboard.
module regwrite_arb
  import regwrite_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int QDEPTH = 2
) (
  input logic             Clk,
  input logic             Rst,
  regwrite_arb_if.slave   port_if
);

  tag_t              seq_q, seq_d;
  logic              rr_q, rr_d;
  logic              wr_en_q, wr_en_d;
  reg_idx_t          wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              a_full, b_full;
  logic              a_fire, b_fire;
  logic              a_push, b_push;
  tag_t              a_tag, b_tag;
  logic              a_hv, b_hv;
  tag_t              a_htag, b_htag;
  reg_idx_t          a_hreg, b_hreg;
  logic [DATA_W-1:0] a_hdata, b_hdata;
  logic [31:0]       a_occ, b_occ;
  logic              grant_a, grant_b;
  logic [31:0]       busy_vec;

  assign port_if.a_ready = !a_full;
  assign port_if.b_ready = !b_full;

  // Writes to the zero register complete the handshake but are dropped here.
  assign a_fire = port_if.a_valid && !a_full;
  assign b_fire = port_if.b_valid && !b_full;
  assign a_push = a_fire && (port_if.a_reg != REG_ZR);
  assign b_push = b_fire && (port_if.b_reg != REG_ZR);

  // B counts as older on a simultaneous enqueue, so it takes the current tag.
  assign b_tag = seq_q;
  assign a_tag = seq_q + tag_t'(b_push);
  assign seq_d = seq_q + tag_t'(a_push) + tag_t'(b_push);

  regwrite_queue #(
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_queue_a (
    .clk_i        (Clk),
    .rst_ni       (Rst),
    .push_i       (a_push),
    .push_tag_i   (a_tag),
    .push_reg_i   (port_if.a_reg),
    .push_data_i  (port_if.a_data),
    .pop_i        (grant_a),
    .head_tag_o   (a_htag),
    .head_reg_o   (a_hreg),
    .head_data_o  (a_hdata),
    .head_valid_o (a_hv),
    .full_o       (a_full),
    .occ_mask_o   (a_occ)
  );

  regwrite_queue #(
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_queue_b (
    .clk_i        (Clk),
    .rst_ni       (Rst),
    .push_i       (b_push),
    .push_tag_i   (b_tag),
    .push_reg_i   (port_if.b_reg),
    .push_data_i  (port_if.b_data),
    .pop_i        (grant_b),
    .head_tag_o   (b_htag),
    .head_reg_o   (b_hreg),
    .head_data_o  (b_hdata),
    .head_valid_o (b_hv),
    .full_o       (b_full),
    .occ_mask_o   (b_occ)
  );

  // Same-register heads resolve by age and leave the round-robin pointer alone.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_d    = rr_q;
    if (a_hv && b_hv) begin
      if (a_hreg == b_hreg) begin
        if (tag_older(a_htag, b_htag)) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (rr_q == RR_A) begin
        grant_a = 1'b1;
        rr_d    = RR_B;
      end else begin
        grant_b = 1'b1;
        rr_d    = RR_A;
      end
    end else if (a_hv) begin
      grant_a = 1'b1;
    end else if (b_hv) begin
      grant_b = 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = grant_a || grant_b;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (grant_a) begin
      wr_reg_d  = a_hreg;
      wr_data_d = a_hdata;
    end else if (grant_b) begin
      wr_reg_d  = b_hreg;
      wr_data_d = b_hdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      seq_q     <= '0;
      rr_q      <= RR_A;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      seq_q     <= seq_d;
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    busy_vec = a_occ | b_occ;
    if (wr_en_q) begin
      busy_vec[wr_reg_q] = 1'b1;
    end
    busy_vec[REG_ZR] = 1'b0;
  end

  assign port_if.wr_en   = wr_en_q;
  assign port_if.wr_reg  = wr_reg_q;
  assign port_if.wr_data = wr_data_q;
  assign port_if.busy    = busy_vec;

  assign port_if.dbg.seq     = seq_q;
  assign port_if.dbg.rr      = rr_q;
  assign port_if.dbg.grant_a = grant_a;
  assign port_if.dbg.grant_b = grant_b;

endmodule

// File: tb/tb_regwrite_arb.sv
// Bench for regwrite_arb: directed vector table, corner sequences, and random traffic
// against a queue-based reference model.
module tb_regwrite_arb;
  import regwrite_arb_pkg::*;

  localparam int DATA_W = 64;
  localparam int QDEPTH = 2;

  logic Clk;
  logic Rst;

  regwrite_arb_if #(.DATA_W(DATA_W)) port_if ();

  regwrite_arb #(
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .port_if (port_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Entries carry an unbounded arrival number, so "older" is a plain integer compare.
  typedef struct {
    int                seq;
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } ment_t;

  ment_t             mqa[$];
  ment_t             mqb[$];
  int                m_seq;
  bit                m_rr_b;
  bit                m_wr_en;
  logic [4:0]        m_wr_reg;
  logic [DATA_W-1:0] m_wr_data;

  task automatic model_reset();
    mqa.delete();
    mqb.delete();
    m_seq     = 0;
    m_rr_b    = 1'b0;
    m_wr_en   = 1'b0;
    m_wr_reg  = '0;
    m_wr_data = '0;
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (mqa[i]) b[mqa[i].r] = 1'b1;
    foreach (mqb[i]) b[mqb[i].r] = 1'b1;
    if (m_wr_en) b[m_wr_reg] = 1'b1;
    b[31] = 1'b0;
    return b;
  endfunction

  task automatic model_edge(input logic av, input logic [4:0] ar, input logic [DATA_W-1:0] ad,
                            input logic bv, input logic [4:0] br, input logic [DATA_W-1:0] bd);
    bit    a_rdy, b_rdy, ga, gb;
    ment_t e;
    a_rdy = mqa.size() < QDEPTH;
    b_rdy = mqb.size() < QDEPTH;
    ga = 1'b0;
    gb = 1'b0;
    if (mqa.size() > 0 && mqb.size() > 0) begin
      if (mqa[0].r == mqb[0].r) begin
        ga = mqa[0].seq < mqb[0].seq;
        gb = !ga;
      end else begin
        ga = !m_rr_b;
        gb = m_rr_b;
        m_rr_b = ga;
      end
    end else begin
      ga = mqa.size() > 0;
      gb = mqb.size() > 0;
    end
    if (ga) begin
      e = mqa.pop_front();
      m_wr_en = 1'b1; m_wr_reg = e.r; m_wr_data = e.d;
    end else if (gb) begin
      e = mqb.pop_front();
      m_wr_en = 1'b1; m_wr_reg = e.r; m_wr_data = e.d;
    end else begin
      m_wr_en = 1'b0;
    end
    if (bv && b_rdy && br != 5'd31) begin
      e.seq = m_seq; e.r = br; e.d = bd;
      mqb.push_back(e);
      m_seq++;
    end
    if (av && a_rdy && ar != 5'd31) begin
      e.seq = m_seq; e.r = ar; e.d = ad;
      mqa.push_back(e);
      m_seq++;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("a_ready", 64'(port_if.a_ready), 64'(mqa.size() < QDEPTH));
    check("b_ready", 64'(port_if.b_ready), 64'(mqb.size() < QDEPTH));
    check("wr_en",   64'(port_if.wr_en),   64'(m_wr_en));
    check("wr_reg",  64'(port_if.wr_reg),  64'(m_wr_reg));
    check("wr_data", port_if.wr_data,      m_wr_data);
    check("busy",    64'(port_if.busy),    64'(model_busy()));
    check("seq",     64'(port_if.dbg.seq), 64'(m_seq % 8));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [4:0] ar, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [4:0] br, input logic [DATA_W-1:0] bd);
    port_if.a_valid = av; port_if.a_reg = ar; port_if.a_data = ad;
    port_if.b_valid = bv; port_if.b_reg = br; port_if.b_data = bd;
  endtask

  // Called at a negedge: check current outputs, drive, take one edge, return at next negedge.
  task automatic do_cycle(input logic av, input logic [4:0] ar, input logic [DATA_W-1:0] ad,
                          input logic bv, input logic [4:0] br, input logic [DATA_W-1:0] bd);
    check_outputs();
    drive(av, ar, ad, bv, br, bd);
    @(posedge Clk);
    model_edge(av, ar, ad, bv, br, bd);
    @(negedge Clk);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  // Reset with both requesters offering writes, which must be ignored.
  task automatic do_reset();
    Rst = 1'b0;
    drive(1'b1, 5'd7, 64'hDEAD, 1'b1, 5'd8, 64'hBEEF);
    @(posedge Clk);
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [63:0] bd;
    logic        e_wr_en;
    logic [4:0]  e_wr_reg;
    logic [63:0] e_wr_data;
    logic [31:0] e_busy;
    logic        e_ar;
    logic        e_br;
    logic [2:0]  e_seq;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  logic [4:0] exp_q[$];
  logic [4:0] wlog[$];

  initial begin
    Rst = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    check("rst_wr_en",   64'(port_if.wr_en),   64'd0);
    check("rst_wr_reg",  64'(port_if.wr_reg),  64'd0);
    check("rst_wr_data", port_if.wr_data,      64'd0);
    check("rst_busy",    64'(port_if.busy),    64'd0);
    check("rst_a_ready", 64'(port_if.a_ready), 64'd1);
    check("rst_b_ready", 64'(port_if.b_ready), 64'd1);

    //          av   ar     ad       bv   br     bd       wr_en wr_reg wr_data  busy          ar    br    seq
    vecs[0]  = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b0, 5'd0, 64'h0,  32'h0,        1'b1, 1'b1, 3'd0};
    vecs[1]  = '{1'b1, 5'd3,  64'h11, 1'b0, 5'd0,  64'h0,  1'b0, 5'd0, 64'h0,  32'h0000_0008, 1'b1, 1'b1, 3'd1};
    vecs[2]  = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b1, 5'd3, 64'h11, 32'h0000_0008, 1'b1, 1'b1, 3'd1};
    vecs[3]  = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b0, 5'd3, 64'h11, 32'h0,        1'b1, 1'b1, 3'd1};
    vecs[4]  = '{1'b1, 5'd5,  64'hAA, 1'b1, 5'd5,  64'hBB, 1'b0, 5'd3, 64'h11, 32'h0000_0020, 1'b1, 1'b1, 3'd3};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b1, 5'd5, 64'hBB, 32'h0000_0020, 1'b1, 1'b1, 3'd3};
    vecs[6]  = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b1, 5'd5, 64'hAA, 32'h0000_0020, 1'b1, 1'b1, 3'd3};
    vecs[7]  = '{1'b1, 5'd31, 64'h77, 1'b0, 5'd0,  64'h0,  1'b0, 5'd5, 64'hAA, 32'h0,        1'b1, 1'b1, 3'd3};
    vecs[8]  = '{1'b1, 5'd9,  64'h99, 1'b1, 5'd31, 64'h55, 1'b0, 5'd5, 64'hAA, 32'h0000_0200, 1'b1, 1'b1, 3'd4};
    vecs[9]  = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b1, 5'd9, 64'h99, 32'h0000_0200, 1'b1, 1'b1, 3'd4};
    vecs[10] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b0, 5'd9, 64'h99, 32'h0,        1'b1, 1'b1, 3'd4};
    vecs[11] = '{1'b1, 5'd4,  64'h44, 1'b1, 5'd6,  64'h66, 1'b0, 5'd9, 64'h99, 32'h0000_0050, 1'b1, 1'b1, 3'd6};
    vecs[12] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b1, 5'd4, 64'h44, 32'h0000_0050, 1'b1, 1'b1, 3'd6};
    vecs[13] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b1, 5'd6, 64'h66, 32'h0000_0040, 1'b1, 1'b1, 3'd6};
    vecs[14] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  1'b0, 5'd6, 64'h66, 32'h0,        1'b1, 1'b1, 3'd6};

    for (int i = 0; i < NVEC; i++) begin
      do_cycle(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      check($sformatf("vec%0d_wr_en", i),   64'(port_if.wr_en),   64'(vecs[i].e_wr_en));
      check($sformatf("vec%0d_wr_reg", i),  64'(port_if.wr_reg),  64'(vecs[i].e_wr_reg));
      check($sformatf("vec%0d_wr_data", i), port_if.wr_data,      vecs[i].e_wr_data);
      check($sformatf("vec%0d_busy", i),    64'(port_if.busy),    64'(vecs[i].e_busy));
      check($sformatf("vec%0d_a_ready", i), 64'(port_if.a_ready), 64'(vecs[i].e_ar));
      check($sformatf("vec%0d_b_ready", i), 64'(port_if.b_ready), 64'(vecs[i].e_br));
      check($sformatf("vec%0d_seq", i),     64'(port_if.dbg.seq), 64'(vecs[i].e_seq));
    end

    // Continuous streaming on both requesters: one write per cycle, alternating A,B.
    begin
      int a_next, b_next, acc;
      bit a_ok, b_ok, st;
      do_reset();
      a_next = 1; b_next = 16; acc = 0;
      wlog.delete();
      for (int c = 0; c < 14; c++) begin
        st   = (c < 8);
        a_ok = mqa.size() < QDEPTH;
        b_ok = mqb.size() < QDEPTH;
        do_cycle(st, 5'(a_next), DATA_W'(a_next * 257), st, 5'(b_next), DATA_W'(b_next * 513));
        if (st && a_ok) begin a_next++; acc++; end
        if (st && b_ok) begin b_next++; acc++; end
        if (port_if.wr_en) wlog.push_back(port_if.wr_reg);
        if (c >= 1 && c <= 8) check($sformatf("stream_wr_en_c%0d", c), 64'(port_if.wr_en), 64'd1);
      end
      check("stream_count", 64'(wlog.size()), 64'(acc));
      for (int i = 0; i < 8 && i < wlog.size(); i++)
        check($sformatf("stream_alt%0d", i), 64'(wlog[i] >= 5'd16), 64'(i % 2));
    end

    // Fill queue B behind A traffic, then confirm B drains in enqueue order.
    begin
      do_reset();
      exp_q.delete();
      do_cycle(1'b1, 5'd1, 64'h101, 1'b1, 5'd10, 64'h1010);
      exp_q.push_back(5'd10);
      do_cycle(1'b1, 5'd2, 64'h102, 1'b1, 5'd11, 64'h1011);
      exp_q.push_back(5'd11);
      check("fill_b_ready_full", 64'(port_if.b_ready), 64'd0);
      check("fill_a_ready",      64'(port_if.a_ready), 64'd1);
      do_cycle(1'b1, 5'd3, 64'h103, 1'b1, 5'd12, 64'h1012);
      for (int c = 0; c < 6; c++) begin
        if (port_if.wr_en && port_if.wr_reg >= 5'd10) begin
          if (exp_q.size() == 0) check("drain_extra_b_write", 64'(port_if.wr_reg), 64'h1f);
          else check("drain_b_order", 64'(port_if.wr_reg), 64'(exp_q.pop_front()));
        end
        do_idle(1);
      end
      check("drain_b_left", 64'(exp_q.size()), 64'd0);
    end

    // Reset with queues loaded and a write in flight: everything is discarded.
    begin
      do_reset();
      do_cycle(1'b1, 5'd1, 64'h201, 1'b1, 5'd3, 64'h203);
      do_cycle(1'b1, 5'd2, 64'h202, 1'b1, 5'd4, 64'h204);
      do_cycle(1'b1, 5'd5, 64'h205, 1'b1, 5'd6, 64'h206);
      do_reset();
      check("mid_rst_wr_en",   64'(port_if.wr_en),   64'd0);
      check("mid_rst_busy",    64'(port_if.busy),    64'd0);
      check("mid_rst_a_ready", 64'(port_if.a_ready), 64'd1);
      check("mid_rst_b_ready", 64'(port_if.b_ready), 64'd1);
      for (int c = 0; c < 4; c++) begin
        do_idle(1);
        check($sformatf("mid_rst_no_stale%0d", c), 64'(port_if.wr_en), 64'd0);
      end
    end

    // Random traffic with frequent same-register collisions and occasional resets.
    begin
      logic       av, bv;
      logic [4:0] ar, br;
      int         ra, rb;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 63) == 0) begin
          do_reset();
        end else begin
          av = ($urandom_range(0, 9) < 6);
          bv = ($urandom_range(0, 9) < 6);
          ra = $urandom_range(0, 9);
          rb = $urandom_range(0, 9);
          ar = (ra == 9) ? 5'd31 : 5'(ra);
          br = (rb == 9) ? 5'd31 : 5'(rb);
          do_cycle(av, ar, {$urandom, $urandom}, bv, br, {$urandom, $urandom});
        end
      end
      do_idle(6);
      check("final_busy", 64'(port_if.busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
